thermo_pattern_gen: RTL



---
 rtl/tdc_pkg.sv | 13 +
 rtl/thermo_decode.sv | 20 ++
 rtl/thermo_pattern_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared TDC widths and pattern-generator FSM encoding
package tdc_pkg;

    localparam int BIN_W    = 5;
    localparam int THERMO_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } gen_state_e;

endpackage

// File: rtl/thermo_decode.sv
// rtl/thermo_decode.sv - combinational binary-to-thermometer decode
module thermo_decode
    import tdc_pkg::*;
#(
    parameter int BIN_W    = tdc_pkg::BIN_W,
    parameter int THERMO_W = tdc_pkg::THERMO_W
) (
    input  logic [BIN_W-1:0]    bin_i,
    output logic [THERMO_W-1:0] thermo_o
);

    // Bit i is set for every position below the code value.
    always_comb begin
        thermo_o = '0;
        for (int i = 0; i < THERMO_W; i++) begin
            thermo_o[i] = (i < int'(bin_i));
        end
    end

endmodule

// File: rtl/thermo_pattern_gen.sv
// rtl/thermo_pattern_gen.sv - handshake or sweep driven thermometer pattern source
module thermo_pattern_gen
    import tdc_pkg::*;
#(
    parameter int BIN_W    = tdc_pkg::BIN_W,
    parameter int THERMO_W = tdc_pkg::THERMO_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic                start,
    input  logic                in_valid,
    input  logic [BIN_W-1:0]    in_bin,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [THERMO_W-1:0] out_thermo,
    output logic [BIN_W-1:0]    out_bin,
    output logic                busy,
    output logic                done
);

    localparam logic [BIN_W-1:0] CODE_LAST = '1;

    gen_state_e          state_q, state_d;
    logic [BIN_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [THERMO_W-1:0] thermo_q, thermo_d;
    logic                done_q, done_d;

    logic                slot_free;
    logic                load;
    logic [BIN_W-1:0]    load_bin;
    logic [THERMO_W-1:0] load_thermo;

    thermo_decode #(
        .BIN_W    (BIN_W),
        .THERMO_W (THERMO_W)
    ) u_decode (
        .bin_i    (load_bin),
        .thermo_o (load_thermo)
    );

    assign slot_free = !valid_q || out_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        bin_d    = bin_q;
        thermo_d = thermo_q;
        done_d   = 1'b0;
        load     = 1'b0;
        load_bin = '0;

        // A free slot drops the held beat unless something reloads it below.
        if (slot_free) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!mode) begin
                    if (in_valid && slot_free) begin
                        load     = 1'b1;
                        load_bin = in_bin;
                    end
                end else if (start && slot_free) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (slot_free) begin
                    load     = 1'b1;
                    load_bin = cnt_q;
                    if (cnt_q == CODE_LAST) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (slot_free) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            valid_d  = 1'b1;
            bin_d    = load_bin;
            thermo_d = load_thermo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            bin_q    <= '0;
            thermo_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            bin_q    <= bin_d;
            thermo_q <= thermo_d;
            done_q   <= done_d;
        end
    end

    // Gated by rst_n so the handshake is refused while reset is held.
    assign in_ready   = rst_n && (state_q == ST_IDLE) && !mode && slot_free;
    assign out_valid  = valid_q;
    assign out_bin    = bin_q;
    assign out_thermo = thermo_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

endmodule
